wb_retire_checker: RTL

WB_RETIRE_CHECKER -- requirements
Module: wb_retire_checker

---
 rtl/wb_check_pkg.sv | 48 ++++
 rtl/wb_check_fifo.sv | 78 +++++++
 rtl/wb_retire_checker.sv | 137 +++++++++++++
 3 files changed

// File: rtl/wb_check_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wb_check_pkg
//  Description : Shared types and constants for the writeback retire checker:
//                the expectation record, the error-code enum, the LIL opcode
//                and the opcode field bounds.
//  Revision    : 1.0 - initial release
// ============================================================================
package wb_check_pkg;

    localparam int c_PC_W   = 36;
    localparam int c_INST_W = 32;
    localparam int c_REG_W  = 5;
    localparam int c_DATA_W = 36;

    // Opcode field position inside the instruction word
    localparam int c_OPC_MSB = 6;
    localparam int c_OPC_LSB = 0;

    // Opcode of the "lil" instruction, which only defines its low 18 data bits
    localparam logic [c_OPC_MSB-c_OPC_LSB:0] LIL_OPCODE = 7'h5B;

    localparam logic [c_INST_W-1:0] c_OPC_MASK =
        ((c_INST_W'(1) << (c_OPC_MSB - c_OPC_LSB + 1)) - c_INST_W'(1)) << c_OPC_LSB;
    localparam logic [c_DATA_W-1:0] c_LIL_DATA_MASK = c_DATA_W'(36'h0_0003_FFFF);

    typedef struct packed {
        logic [c_PC_W-1:0]   pc;
        logic [c_INST_W-1:0] inst;
        logic                wb;
        logic [c_REG_W-1:0]  rd;
        logic [c_DATA_W-1:0] data;
    } wb_rec_t;

    typedef enum logic [1:0] {
        ERR_NONE      = 2'd0,
        ERR_MISMATCH  = 2'd1,
        ERR_UNDERFLOW = 2'd2,
        ERR_OVERFLOW  = 2'd3
    } err_code_e;

    // True when the instruction word carries the LIL opcode
    function automatic logic is_lil(input logic [c_INST_W-1:0] inst);
        return (inst & c_OPC_MASK) == (c_INST_W'(LIL_OPCODE) << c_OPC_LSB);
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_check_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : wb_check_fifo
//  Description : Synchronous FIFO of expectation records.
//                clk/rst  : clock, synchronous active-high reset
//                i_push   : write i_wdata (ignored when full without a pop)
//                i_pop    : advance the head (ignored when empty)
//                o_rdata  : head record
//                o_full / o_empty / o_count : status derived from occupancy
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_check_fifo
    import wb_check_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  wb_rec_t                i_wdata,
    input  logic                   i_pop,
    output wb_rec_t                o_rdata,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int c_AW = $clog2(DEPTH);
    localparam logic [c_AW:0]   c_CNT_ONE = (c_AW+1)'(1);
    localparam logic [c_AW:0]   c_FULL    = (c_AW+1)'(DEPTH);
    localparam logic [c_AW-1:0] c_PTR_ONE = c_AW'(1);

    wb_rec_t         r_mem [DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_count;

    logic w_do_pop;
    logic w_do_push;

    assign o_full    = (r_count == c_FULL);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rd_ptr];

    assign w_do_pop  = !rst && i_pop && !o_empty;
    // A full FIFO can still accept a write when the head leaves this cycle
    assign w_do_push = !rst && i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // Power-of-two depth: pointers wrap naturally
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_retire_checker.sv
`default_nettype none
// ============================================================================
//  Module      : wb_retire_checker
//  Description : Compares each processor retirement against the next queued
//                expectation record and reports the result one cycle later.
//                exp_*      : expectation push port (exp_ready = accepted)
//                ret_*      : retire strobe and writeback observed at retire
//                chk_*      : registered per-check result pulse
//                err/err_code : sticky first error
//                checked_cnt/occupancy : statistics and record count
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_retire_checker
    import wb_check_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   exp_valid,
    output logic                   exp_ready,
    input  logic [35:0]            exp_pc,
    input  logic [31:0]            exp_inst,
    input  logic                   exp_wb,
    input  logic [4:0]             exp_reg,
    input  logic [35:0]            exp_data,
    input  logic                   ret_valid,
    input  logic                   ret_wb_en,
    input  logic [4:0]             ret_reg,
    input  logic [35:0]            ret_data,
    output logic                   chk_valid,
    output logic                   chk_fail,
    output logic [35:0]            chk_pc,
    output logic                   err,
    output logic [1:0]             err_code,
    output logic [31:0]            checked_cnt,
    output logic [$clog2(DEPTH):0] occupancy
);

    wb_rec_t   w_wr_rec;
    wb_rec_t   w_head;
    logic      w_full;
    logic      w_empty;
    logic      w_push;
    logic      w_pop;
    logic      w_underflow;
    logic      w_overflow;
    logic      w_fail;
    logic [35:0] w_data_mask;
    err_code_e w_new_err;

    logic        r_chk_valid;
    logic        r_chk_fail;
    logic [35:0] r_chk_pc;
    logic        r_err;
    err_code_e   r_err_code;
    logic [31:0] r_checked_cnt;

    assign w_wr_rec = '{pc: exp_pc, inst: exp_inst, wb: exp_wb, rd: exp_reg, data: exp_data};

    // Full only blocks a push when no retire frees a slot in the same cycle
    assign exp_ready   = !rst && (!w_full || ret_valid);
    assign w_push      = exp_valid && exp_ready;
    assign w_pop       = !rst && ret_valid && !w_empty;
    // A same-cycle push never bypasses to an empty queue
    assign w_underflow = !rst && ret_valid && w_empty;
    assign w_overflow  = !rst && exp_valid && !exp_ready;

    wb_check_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata (w_wr_rec),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (occupancy)
    );

    always_comb begin
        w_data_mask = is_lil(w_head.inst) ? c_LIL_DATA_MASK : '1;
        w_fail      = 1'b0;
        if (w_head.wb) begin
            w_fail = !ret_wb_en
                  || (ret_reg != w_head.rd)
                  || (((ret_data ^ w_head.data) & w_data_mask) != '0);
        end else begin
            w_fail = ret_wb_en;
        end
    end

    // Mismatch, underflow and overflow are mutually exclusive in any one cycle
    always_comb begin
        w_new_err = ERR_NONE;
        if (w_pop && w_fail) begin
            w_new_err = ERR_MISMATCH;
        end else if (w_underflow) begin
            w_new_err = ERR_UNDERFLOW;
        end else if (w_overflow) begin
            w_new_err = ERR_OVERFLOW;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_chk_valid   <= 1'b0;
            r_chk_fail    <= 1'b0;
            r_chk_pc      <= '0;
            r_err         <= 1'b0;
            r_err_code    <= ERR_NONE;
            r_checked_cnt <= '0;
        end else begin
            r_chk_valid <= w_pop;
            r_chk_fail  <= w_pop && w_fail;
            if (w_pop) begin
                r_chk_pc      <= w_head.pc;
                r_checked_cnt <= r_checked_cnt + 32'd1;
            end
            if (!r_err && (w_new_err != ERR_NONE)) begin
                r_err      <= 1'b1;
                r_err_code <= w_new_err;
            end
        end
    end

    assign chk_valid   = r_chk_valid;
    assign chk_fail    = r_chk_fail;
    assign chk_pc      = r_chk_pc;
    assign err         = r_err;
    assign err_code    = r_err_code;
    assign checked_cnt = r_checked_cnt;

endmodule
`default_nettype wire
